// File: rtl/cdac_load_sched.sv
// cdac_load_sched: shares the serial threshold DAC between the JTAG and
// auto-load paths, sequencing clear/capture/done with timeout and retry.
module cdac_load_sched #(
  parameter int unsigned TMO_CYCLES = 1024,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic        CLK40,
  input  logic        RST_B,
  input  logic        JTAG_REQ,
  input  logic [11:0] JTAG_DATA,
  input  logic        AL_REQ,
  input  logic [11:0] AL_DATA,
  input  logic        CDAC_DONE,
  input  logic        ERR_CLR,
  output logic        CAPTURE,
  output logic [11:0] CDAC_DATA,
  output logic        CLR_DONE,
  output logic        JTAG_ACK,
  output logic        AL_ACK,
  output logic        BUSY,
  output logic        CUR_SRC,
  output logic        ERR
);

  localparam int TW = $clog2(TMO_CYCLES + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
  localparam logic [TW-1:0] TMO_SAT  = TW'(TMO_CYCLES);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAIN,
    S_LAUNCH,
    S_WAIT,
    S_ACK
  } state_t;

  state_t        state_q;
  logic          pend_j_q;
  logic          pend_a_q;
  logic          last_j_q;
  logic [11:0]   data_j_q;
  logic [11:0]   data_a_q;
  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;
  logic [RW-1:0] retry_q;
  logic          cap_q;
  logic          clr_q;
  logic          jack_q;
  logic          aack_q;
  logic          busy_q;
  logic          src_q;
  logic          err_q;
  logic [11:0]   cdac_q;

  logic gnt_j;
  logic gnt_a;
  logic expire;
  logic err_set;

  // round-robin: on a tie the source that did not win last time goes
  always_comb begin
    gnt_j = 1'b0;
    gnt_a = 1'b0;
    if (state_q == S_IDLE) begin
      if (pend_j_q && pend_a_q) begin
        gnt_j = ~last_j_q;
        gnt_a = last_j_q;
      end else begin
        gnt_j = pend_j_q;
        gnt_a = pend_a_q;
      end
    end
  end

  assign tmr_d = (tmr_q < TMO_SAT) ? tmr_q + TW'(1) : tmr_q;

  assign expire = (tmr_q == TMO_LAST) &&
                  ((state_q == S_DRAIN && CDAC_DONE) ||
                   (state_q == S_WAIT && !CDAC_DONE));

  assign err_set = expire && (retry_q == RTY_MAX);

  always_ff @(posedge CLK40 or negedge RST_B) begin
    if (!RST_B) begin
      state_q  <= S_IDLE;
      pend_j_q <= 1'b0;
      pend_a_q <= 1'b0;
      last_j_q <= 1'b1;
      data_j_q <= '0;
      data_a_q <= '0;
      tmr_q    <= '0;
      retry_q  <= '0;
      cap_q    <= 1'b0;
      clr_q    <= 1'b0;
      jack_q   <= 1'b0;
      aack_q   <= 1'b0;
      busy_q   <= 1'b0;
      src_q    <= 1'b0;
      err_q    <= 1'b0;
      cdac_q   <= '0;
    end else begin
      pend_j_q <= JTAG_REQ | (pend_j_q & ~gnt_j);
      pend_a_q <= AL_REQ | (pend_a_q & ~gnt_a);
      if (JTAG_REQ) data_j_q <= JTAG_DATA;
      if (AL_REQ)   data_a_q <= AL_DATA;

      cap_q  <= 1'b0;
      clr_q  <= 1'b0;
      jack_q <= 1'b0;
      aack_q <= 1'b0;

      if (err_set)      err_q <= 1'b1;
      else if (ERR_CLR) err_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (gnt_j || gnt_a) begin
            state_q  <= S_CLEAR;
            busy_q   <= 1'b1;
            clr_q    <= 1'b1;
            cdac_q   <= gnt_j ? data_j_q : data_a_q;
            src_q    <= gnt_j;
            last_j_q <= gnt_j;
            retry_q  <= '0;
          end
        end
        S_CLEAR: begin
          state_q <= S_DRAIN;
          tmr_q   <= '0;
        end
        S_DRAIN, S_WAIT: begin
          tmr_q <= tmr_d;
          if (state_q == S_DRAIN && !CDAC_DONE) begin
            state_q <= S_LAUNCH;
            cap_q   <= 1'b1;
          end else if (state_q == S_WAIT && CDAC_DONE) begin
            state_q <= S_ACK;
            jack_q  <= src_q;
            aack_q  <= ~src_q;
          end else if (expire) begin
            if (retry_q < RTY_MAX) begin
              retry_q <= retry_q + RW'(1);
              state_q <= S_CLEAR;
              clr_q   <= 1'b1;
            end else begin
              state_q <= S_ACK;
              jack_q  <= src_q;
              aack_q  <= ~src_q;
            end
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT;
          tmr_q   <= '0;
        end
        S_ACK: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign CAPTURE   = cap_q;
  assign CDAC_DATA = cdac_q;
  assign CLR_DONE  = clr_q;
  assign JTAG_ACK  = jack_q;
  assign AL_ACK    = aack_q;
  assign BUSY      = busy_q;
  assign CUR_SRC   = src_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_cdac_load_sched.sv
// tb_cdac_load_sched: scoreboard bench with a loader model and a
// transaction-level round-robin reference for cdac_load_sched.
module tb_cdac_load_sched;

  localparam int TMO = 1024;

  logic        CLK40;
  logic        RST_B;
  logic        JTAG_REQ;
  logic [11:0] JTAG_DATA;
  logic        AL_REQ;
  logic [11:0] AL_DATA;
  logic        CDAC_DONE;
  logic        ERR_CLR;
  logic        CAPTURE;
  logic [11:0] CDAC_DATA;
  logic        CLR_DONE;
  logic        JTAG_ACK;
  logic        AL_ACK;
  logic        BUSY;
  logic        CUR_SRC;
  logic        ERR;

  cdac_load_sched #(.TMO_CYCLES(TMO), .MAX_RETRY(2)) dut (
    .CLK40(CLK40), .RST_B(RST_B),
    .JTAG_REQ(JTAG_REQ), .JTAG_DATA(JTAG_DATA),
    .AL_REQ(AL_REQ), .AL_DATA(AL_DATA),
    .CDAC_DONE(CDAC_DONE), .ERR_CLR(ERR_CLR),
    .CAPTURE(CAPTURE), .CDAC_DATA(CDAC_DATA),
    .CLR_DONE(CLR_DONE), .JTAG_ACK(JTAG_ACK),
    .AL_ACK(AL_ACK), .BUSY(BUSY),
    .CUR_SRC(CUR_SRC), .ERR(ERR)
  );

  typedef struct packed {
    logic        src;
    logic [11:0] data;
  } cap_t;

  typedef struct packed {
    logic src;
    logic err;
  } ack_t;

  cap_t exp_cap[$];
  ack_t exp_ack[$];
  int   cap_hist[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_cap = 0;
  int n_jack = 0;
  int n_aack = 0;

  // loader model controls
  int ld_lat = 20;
  bit ld_stuck = 0;

  // reference model: pending flag and latest data per source
  bit          m_pend[2];
  logic [11:0] m_data[2];
  bit          m_last;
  bit          m_err;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0d", nm, act, req, cyc);
    end
  endfunction

  function automatic void fail(string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none t=%0d", nm, cyc);
  endfunction

  function automatic void m_reset();
    m_pend[0] = 0;
    m_pend[1] = 0;
    m_data[0] = '0;
    m_data[1] = '0;
    m_last = 1;
    m_err = 0;
    exp_cap.delete();
    exp_ack.delete();
  endfunction

  function automatic void m_req(bit s, logic [11:0] d);
    m_pend[s] = 1;
    m_data[s] = d;
  endfunction

  function automatic void m_grant(int ncap, bit err);
    bit s;
    if (!m_pend[0] && !m_pend[1]) return;
    if (m_pend[0] && m_pend[1]) s = ~m_last;
    else s = m_pend[1];
    m_pend[s] = 0;
    m_last = s;
    for (int i = 0; i < ncap; i++) exp_cap.push_back('{s, m_data[s]});
    exp_ack.push_back('{s, err});
  endfunction

  function automatic void m_drain();
    while (m_pend[0] || m_pend[1]) m_grant(1, m_err);
  endfunction

  initial begin
    CLK40 = 0;
    forever #5 CLK40 = ~CLK40;
  end

  initial forever begin
    @(posedge CLK40);
    cyc++;
  end

  // loader: done is sticky until cleared, raised ld_lat cycles after capture
  initial begin
    int cnt;
    bit prev;
    cnt = 0;
    prev = 0;
    CDAC_DONE = 0;
    forever begin
      @(posedge CLK40);
      #1;
      if (!RST_B) begin
        CDAC_DONE = 0;
        cnt = 0;
        prev = 0;
      end else if (ld_stuck) begin
        CDAC_DONE = 1;
        prev = 1;
      end else begin
        if (prev) begin
          CDAC_DONE = 0;
          prev = 0;
        end
        if (CLR_DONE) CDAC_DONE = 0;
        if (CAPTURE) cnt = ld_lat;
        else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) CDAC_DONE = 1;
        end
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a capture or ack
  initial begin
    bit saw_clr;
    bit ack_prev;
    cap_t ec;
    ack_t ea;
    saw_clr = 0;
    ack_prev = 0;
    forever begin
      @(negedge CLK40);
      if (!RST_B) begin
        saw_clr = 0;
        ack_prev = 0;
      end else begin
        if (ack_prev) chk("busy_after_ack", BUSY, 0);
        ack_prev = JTAG_ACK | AL_ACK;
        if (CLR_DONE) saw_clr = 1;
        if (CAPTURE) begin
          n_cap++;
          cap_hist.push_back(cyc);
          chk("clr_before_cap", saw_clr, 1);
          saw_clr = 0;
          if (exp_cap.size() == 0) fail("unexpected_capture");
          else begin
            ec = exp_cap.pop_front();
            chk("cap_data", CDAC_DATA, ec.data);
            chk("cap_src", CUR_SRC, ec.src);
          end
        end
        if (JTAG_ACK || AL_ACK) begin
          if (JTAG_ACK) n_jack++;
          if (AL_ACK) n_aack++;
          chk("ack_onehot", JTAG_ACK & AL_ACK, 0);
          chk("ack_busy", BUSY, 1);
          if (exp_ack.size() == 0) fail("unexpected_ack");
          else begin
            ea = exp_ack.pop_front();
            chk("ack_src", JTAG_ACK, ea.src);
            chk("ack_cur_src", CUR_SRC, ea.src);
            chk("ack_err", ERR, ea.err);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic drive(bit a, logic [11:0] ad, bit j, logic [11:0] jd);
    AL_REQ = a;
    AL_DATA = ad;
    JTAG_REQ = j;
    JTAG_DATA = jd;
    if (a) m_req(0, ad);
    if (j) m_req(1, jd);
    @(negedge CLK40);
    AL_REQ = 0;
    JTAG_REQ = 0;
    AL_DATA = 12'($urandom);
    JTAG_DATA = 12'($urandom);
  endtask

  task automatic wait_idle(string nm, int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge CLK40);
      if (!BUSY && exp_cap.size() == 0 && exp_ack.size() == 0) break;
    end
    if (i == budget) begin
      fail({nm, "_idle_timeout"});
      exp_cap.delete();
      exp_ack.delete();
    end
  endtask

  task automatic wait_sig(string nm, bit want_cap, int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge CLK40);
      if (want_cap ? CAPTURE : CLR_DONE) break;
    end
    if (i == budget) fail({nm, "_timeout"});
  endtask

  task automatic do_reset();
    RST_B = 0;
    repeat (2) @(negedge CLK40);
    RST_B = 1;
    m_reset();
    @(negedge CLK40);
  endtask

  function automatic logic [18:0] outs();
    return {CAPTURE, CDAC_DATA, CLR_DONE, JTAG_ACK, AL_ACK, BUSY, CUR_SRC, ERR};
  endfunction

  initial begin
    int c0, c1, c2, t_fall, t_cap;
    logic [11:0] ra, rj;
    bit s;
    int m;
    RST_B = 0;
    JTAG_REQ = 0;
    AL_REQ = 0;
    JTAG_DATA = 12'hFFF;
    AL_DATA = 12'hFFF;
    ERR_CLR = 0;
    m_reset();
    repeat (3) @(negedge CLK40);
    chk("reset_outputs", outs(), 0);
    RST_B = 1;
    @(negedge CLK40);

    // single JTAG load
    ld_lat = 700;
    c0 = n_jack;
    drive(0, 12'h000, 1, 12'hA5C);
    m_grant(1, 0);
    wait_idle("single", 2000);
    chk("single_jack_count", n_jack - c0, 1);
    chk("single_cur_src", CUR_SRC, 1);
    chk("single_err", ERR, 0);

    // simultaneous: AL first after reset, then JTAG
    do_reset();
    ld_lat = 30;
    c0 = n_cap;
    c1 = n_aack;
    c2 = n_jack;
    drive(1, 12'h100, 1, 12'h200);
    m_grant(1, 0);
    m_drain();
    wait_idle("simul", 500);
    chk("simul_cap_count", n_cap - c0, 2);
    chk("simul_aack_count", n_aack - c1, 1);
    chk("simul_jack_count", n_jack - c2, 1);

    // re-request in flight: latest data wins
    ld_lat = 60;
    c0 = n_jack;
    drive(0, 12'h000, 1, 12'h011);
    m_grant(1, 0);
    wait_sig("rereq_cap", 1, 100);
    repeat (3) @(negedge CLK40);
    drive(0, 12'h000, 1, 12'h022);
    @(negedge CLK40);
    drive(0, 12'h000, 1, 12'h033);
    m_drain();
    wait_idle("rereq", 500);
    chk("rereq_jack_count", n_jack - c0, 2);

    // done stuck high across the grant
    ld_lat = 20;
    ld_stuck = 1;
    repeat (2) @(negedge CLK40);
    c0 = n_cap;
    drive(1, 12'h5A5, 0, 12'h000);
    m_grant(1, 0);
    wait_sig("stuck_clr", 0, 20);
    repeat (10) @(negedge CLK40);
    chk("stuck_no_cap", n_cap - c0, 0);
    ld_stuck = 0;
    t_fall = -1;
    t_cap = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK40);
      if (!CDAC_DONE && t_fall < 0) t_fall = cyc;
      if (CAPTURE) begin
        t_cap = cyc;
        break;
      end
    end
    chk("stuck_cap_after_fall", t_cap - t_fall, 1);
    wait_idle("stuck", 200);

    // timeout exhaustion: three launches, wait window plus clear/drain/launch apart
    ld_lat = -1;
    cap_hist.delete();
    rj = 12'($urandom);
    drive(0, 12'h000, 1, rj);
    m_grant(3, 1);
    m_err = 1;
    wait_idle("tmo", 5000);
    chk("tmo_cap_count", cap_hist.size(), 3);
    if (cap_hist.size() == 3) begin
      chk("tmo_gap1", cap_hist[1] - cap_hist[0], TMO + 3);
      chk("tmo_gap2", cap_hist[2] - cap_hist[1], TMO + 3);
    end
    chk("tmo_err_sticky", ERR, 1);
    ERR_CLR = 1;
    @(negedge CLK40);
    ERR_CLR = 0;
    m_err = 0;
    chk("tmo_err_clr", ERR, 0);

    // reset in the middle of WAIT abandons the load
    ld_lat = 50;
    drive(1, 12'($urandom), 0, 12'h000);
    m_grant(1, 0);
    wait_sig("rst_cap", 1, 100);
    repeat (5) @(negedge CLK40);
    RST_B = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK40);
      chk("rst_mid_outputs", outs(), 0);
    end
    RST_B = 1;
    m_reset();
    c0 = n_jack + n_aack;
    repeat (80) @(negedge CLK40);
    chk("rst_no_ack", n_jack + n_aack - c0, 0);
    c1 = n_aack;
    drive(1, 12'h3C3, 0, 12'h000);
    m_grant(1, 0);
    wait_idle("rst_after", 300);
    chk("rst_after_aack", n_aack - c1, 1);

    // randomized traffic against the transaction-level model
    for (int it = 0; it < 25; it++) begin
      ld_lat = $urandom_range(3, 30);
      m = $urandom_range(1, 3);
      ra = 12'($urandom);
      rj = 12'($urandom);
      drive(m[0], ra, m[1], rj);
      m_grant(1, m_err);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 3)) @(negedge CLK40);
        s = 1'($urandom_range(0, 1));
        ra = 12'($urandom);
        drive(!s, ra, s, ra);
      end
      m_drain();
      wait_idle("rand", 600);
    end
    chk("rand_err", ERR, 0);

    repeat (5) @(negedge CLK40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
